// File: rtl/crtc_regs.sv
// 6545-style CRTC CPU register port: address/status and data registers, a staging
// file for the 16 timing registers, and an active copy committed atomically at v_sync.
module crtc_regs #(
  parameter bit COMMIT_ON_VSYNC = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cpu_en_i,
  input  logic       cpu_we_i,
  input  logic       cpu_rs_i,
  input  logic [7:0] cpu_data_i,
  output logic [7:0] cpu_data_o,
  input  logic       v_sync_i,
  output logic [7:0] r0_o,
  output logic [7:0] r1_o,
  output logic [7:0] r2_o,
  output logic [7:0] r3_o,
  output logic [6:0] r4_o,
  output logic [4:0] r5_o,
  output logic [6:0] r6_o,
  output logic [6:0] r7_o,
  output logic [7:0] r8_o,
  output logic [4:0] r9_o,
  output logic [6:0] r10_o,
  output logic [4:0] r11_o,
  output logic [5:0] r12_o,
  output logic [7:0] r13_o,
  output logic [5:0] r14_o,
  output logic [7:0] r15_o,
  output logic       dirty_o
);

  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      4'd4, 4'd6, 4'd7, 4'd10: reg_mask = 8'h7F;
      4'd5, 4'd9, 4'd11:       reg_mask = 8'h1F;
      4'd12, 4'd14:            reg_mask = 8'h3F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] reg_default(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_default = 8'd63;
      4'd1:    reg_default = 8'd40;
      4'd2:    reg_default = 8'd48;
      4'd3:    reg_default = 8'h15;
      4'd4:    reg_default = 8'd32;
      4'd6:    reg_default = 8'd25;
      4'd7:    reg_default = 8'd28;
      4'd9:    reg_default = 8'd7;
      4'd12:   reg_default = 8'h10;
      default: reg_default = 8'h00;
    endcase
  endfunction

  logic [4:0] addr;
  logic [7:0] stage  [16];
  logic [7:0] active [16];
  logic       dirty;
  logic       s0, s1, prev;
  logic       commit;
  logic       wr_addr, wr_data, rd;
  logic [7:0] rd_val;

  assign wr_addr = cpu_en_i & cpu_we_i & ~cpu_rs_i;
  assign wr_data = cpu_en_i & cpu_we_i & cpu_rs_i & ~addr[4];
  assign rd      = cpu_en_i & ~cpu_we_i;
  assign commit  = s1 & ~prev;

  // Status and readable-register mux; only R14/R15 read back, the rest return zero
  always_comb begin
    rd_val = 8'h00;
    if (!cpu_rs_i) begin
      rd_val = {dirty, 1'b0, s1, 5'b00000};
    end else if (addr == 5'd14) begin
      rd_val = stage[14];
    end else if (addr == 5'd15) begin
      rd_val = stage[15];
    end else begin
      rd_val = 8'h00;
    end
  end

  // v_sync is asynchronous to clk_i: two-flop synchronizer plus edge-detect flop
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= v_sync_i;
      s1   <= s0;
      prev <= s1;
    end
  end

  // CPU side: address register, staging file, read data
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr       <= 5'd0;
      cpu_data_o <= 8'h00;
      for (int i = 0; i < 16; i++) stage[i] <= reg_default(4'(i));
    end else begin
      if (wr_addr) addr <= cpu_data_i[4:0];
      if (wr_data) stage[addr[3:0]] <= cpu_data_i & reg_mask(addr[3:0]);
      if (rd) cpu_data_o <= rd_val;
    end
  end

  // Active copy; a write on the commit edge lands in staging only, so dirty stays set
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dirty <= 1'b0;
      for (int i = 0; i < 16; i++) active[i] <= reg_default(4'(i));
    end else begin
      if (!COMMIT_ON_VSYNC || commit) begin
        for (int i = 0; i < 16; i++) active[i] <= stage[i];
      end
      if (!COMMIT_ON_VSYNC) dirty <= 1'b0;
      else if (wr_data)     dirty <= 1'b1;
      else if (commit)      dirty <= 1'b0;
    end
  end

  assign dirty_o = dirty;
  assign r0_o  = active[0];
  assign r1_o  = active[1];
  assign r2_o  = active[2];
  assign r3_o  = active[3];
  assign r4_o  = active[4][6:0];
  assign r5_o  = active[5][4:0];
  assign r6_o  = active[6][6:0];
  assign r7_o  = active[7][6:0];
  assign r8_o  = active[8];
  assign r9_o  = active[9][4:0];
  assign r10_o = active[10][6:0];
  assign r11_o = active[11][4:0];
  assign r12_o = active[12][5:0];
  assign r13_o = active[13];
  assign r14_o = active[14][5:0];
  assign r15_o = active[15];

endmodule

// File: tb/tb_crtc_regs.sv
// Directed bench for crtc_regs: commit-on-vsync instance plus a follow-staging instance.
module tb_crtc_regs;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, we = 1'b0, rs = 1'b0, vs = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout, r0, r1, r2, r3, r8, r13, r15;
  logic [6:0] r4, r6, r7, r10;
  logic [4:0] r5, r9, r11;
  logic [5:0] r12, r14;
  logic       dirty;

  logic [7:0] z_dout, z_r0, z_r1, z_r2, z_r3, z_r8, z_r13, z_r15;
  logic [6:0] z_r4, z_r6, z_r7, z_r10;
  logic [4:0] z_r5, z_r9, z_r11;
  logic [5:0] z_r12, z_r14;
  logic       z_dirty;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  crtc_regs #(.COMMIT_ON_VSYNC(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .cpu_en_i(en), .cpu_we_i(we), .cpu_rs_i(rs),
    .cpu_data_i(din), .cpu_data_o(dout), .v_sync_i(vs),
    .r0_o(r0), .r1_o(r1), .r2_o(r2), .r3_o(r3), .r4_o(r4), .r5_o(r5), .r6_o(r6), .r7_o(r7),
    .r8_o(r8), .r9_o(r9), .r10_o(r10), .r11_o(r11), .r12_o(r12), .r13_o(r13), .r14_o(r14),
    .r15_o(r15), .dirty_o(dirty));

  crtc_regs #(.COMMIT_ON_VSYNC(1'b0)) dut0 (
    .clk_i(clk), .reset_i(reset), .cpu_en_i(en), .cpu_we_i(we), .cpu_rs_i(rs),
    .cpu_data_i(din), .cpu_data_o(z_dout), .v_sync_i(vs),
    .r0_o(z_r0), .r1_o(z_r1), .r2_o(z_r2), .r3_o(z_r3), .r4_o(z_r4), .r5_o(z_r5), .r6_o(z_r6),
    .r7_o(z_r7), .r8_o(z_r8), .r9_o(z_r9), .r10_o(z_r10), .r11_o(z_r11), .r12_o(z_r12),
    .r13_o(z_r13), .r14_o(z_r14), .r15_o(z_r15), .dirty_o(z_dirty));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b1; rs = sel; din = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic sel);
    @(negedge clk);
    en = 1'b1; we = 1'b0; rs = sel;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_r0", r0, 8'd63);
    chk("rst_r1", r1, 8'd40);
    chk("rst_r3", r3, 8'h15);
    chk("rst_r9", {3'b000, r9}, 8'd7);
    chk("rst_r12", {2'b00, r12}, 8'h10);
    chk("rst_dirty", {7'd0, dirty}, 8'h00);
    chk("rst_dout", dout, 8'h00);

    // staged write, no commit yet; follow-staging instance lags one cycle
    cpu_wr(1'b0, 8'd1);
    cpu_wr(1'b1, 8'd32);
    chk("stage_r1", r1, 8'd40);
    chk("stage_dirty", {7'd0, dirty}, 8'h01);
    chk("z_r1_lag", z_r1, 8'd40);
    @(negedge clk);
    chk("z_r1_follow", z_r1, 8'd32);
    chk("z_dirty", {7'd0, z_dirty}, 8'h00);
    cpu_rd(1'b0);
    chk("status_pend", dout, 8'h80);

    // commit lands on the third edge sampling v_sync high
    @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    chk("commit_edge2_r1", r1, 8'd40);
    @(negedge clk);
    chk("commit_edge3_r1", r1, 8'd32);
    chk("commit_dirty", {7'd0, dirty}, 8'h00);

    // write while v_sync held high: no second commit, status shows both bits
    cpu_wr(1'b0, 8'd4);
    chk("addr_no_dirty", {7'd0, dirty}, 8'h00);
    cpu_wr(1'b1, 8'hFF);
    cpu_rd(1'b0);
    chk("status_a0", dout, 8'hA0);
    chk("held_vs_r4", {1'b0, r4}, 8'd32);
    vs = 1'b0;
    cpu_wr(1'b0, 8'd12);
    cpu_wr(1'b1, 8'hFF);
    vsync_pulse();
    chk("mask_r4", {1'b0, r4}, 8'h7F);
    chk("mask_r12", {2'b00, r12}, 8'h3F);
    chk("mask_dirty", {7'd0, dirty}, 8'h00);

    // readable staging registers R14/R15, others read as zero
    cpu_wr(1'b0, 8'd14);
    cpu_wr(1'b1, 8'hFF);
    cpu_rd(1'b1);
    chk("rd_r14", dout, 8'h3F);
    cpu_wr(1'b0, 8'd15);
    cpu_wr(1'b1, 8'hAB);
    cpu_rd(1'b1);
    chk("rd_r15", dout, 8'hAB);
    chk("r15_uncommitted", r15, 8'h00);
    cpu_wr(1'b0, 8'd13);
    cpu_rd(1'b1);
    chk("rd_r13_zero", dout, 8'h00);
    vsync_pulse();
    chk("commit_r14", {2'b00, r14}, 8'h3F);
    chk("commit_r15", r15, 8'hAB);

    // unimplemented index 20
    cpu_wr(1'b0, 8'd20);
    cpu_wr(1'b1, 8'h55);
    chk("idx20_dirty", {7'd0, dirty}, 8'h00);
    cpu_rd(1'b1);
    chk("rd_idx20", dout, 8'h00);
    cpu_wr(1'b0, 8'd0);
    cpu_rd(1'b1);
    chk("rd_r0_zero", dout, 8'h00);
    vsync_pulse();
    chk("idx20_r0", r0, 8'd63);
    chk("idx20_r5", {3'b000, r5}, 8'h00);

    // data write on the commit edge
    cpu_wr(1'b0, 8'd6);
    @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1; we = 1'b1; rs = 1'b1; din = 8'd30;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
    chk("race_r6_old", {1'b0, r6}, 8'd25);
    chk("race_dirty", {7'd0, dirty}, 8'h01);
    vs = 1'b0;
    vsync_pulse();
    chk("race_r6_new", {1'b0, r6}, 8'd30);
    chk("race_dirty_clr", {7'd0, dirty}, 8'h00);

    // write strobe held several cycles repeats the same write
    cpu_wr(1'b0, 8'd8);
    @(negedge clk);
    en = 1'b1; we = 1'b1; rs = 1'b1; din = 8'h12;
    repeat (3) @(negedge clk);
    en = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("hold_z_r8", z_r8, 8'h12);

    // async reset mid-cycle discards pending writes
    cpu_wr(1'b0, 8'd1);
    cpu_wr(1'b1, 8'h11);
    cpu_rd(1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_r1", r1, 8'd40);
    chk("arst_r4", {1'b0, r4}, 8'd32);
    chk("arst_r6", {1'b0, r6}, 8'd25);
    chk("arst_dirty", {7'd0, dirty}, 8'h00);
    chk("arst_dout", dout, 8'h00);
    chk("arst_z_r1", z_r1, 8'd40);
    @(negedge clk);
    reset = 1'b0;
    vsync_pulse();
    chk("arst_discard_r1", r1, 8'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
